// File: rtl/elevator_pkg.sv
// Shared types and floor-code constants for the elevator scheduler slice.
package elevator_pkg;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  localparam int FLOOR_W = 3;
  localparam logic [FLOOR_W-1:0] FLOOR_NONE   = 3'd0;
  localparam logic [FLOOR_W-1:0] FLOOR_BOTTOM = 3'd1;

endpackage

// File: rtl/elevator_tick_timer.sv
// Down-counter paced by the divider tick; shared by the travel and door phases.
module elevator_tick_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && tick && value != '0) begin
      value <= value - 1'b1;
    end
  end

  // done marks the tick that takes the count from 1 to 0
  assign done = en && tick && (value == W'(1));

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-order car scheduler: latches floor requests, steps the car and holds the door.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 5,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TMAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]      MOVE_LOAD = TW'(MOVE_TICKS);
  localparam logic [TW-1:0]      DOOR_LOAD = TW'(DOOR_TICKS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS);

  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
    floor_mask = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (f == FLOOR_W'(i + 1)) floor_mask[i] = 1'b1;
  endfunction

  // {any request elsewhere, direction to take}: keep heading if work lies ahead
  function automatic logic [1:0] pick_dir(input logic [NUM_FLOORS-1:0] m,
                                          input logic [FLOOR_W-1:0]    f,
                                          input logic                  up);
    logic above, below, ahead;
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i + 1) > f)      above = above | m[i];
      else if (FLOOR_W'(i + 1) < f) below = below | m[i];
    end
    ahead    = up ? above : below;
    pick_dir = {above | below, ahead ? up : ~up};
  endfunction

  state_t                state, state_n;
  logic [FLOOR_W-1:0]    floor_n, next_step;
  logic                  dir_n, open_req, open_n;
  logic [NUM_FLOORS-1:0] pend_n, set_mask, clr_mask, req_mask, cur_mask, step_mask;
  logic                  req_ok, req_here, req_step;
  logic                  tmr_load, tmr_done;
  logic [TW-1:0]         tmr_val;
  logic [1:0]            pick;

  assign req_ok    = req_valid && req_floor >= FLOOR_BOTTOM && req_floor <= TOP_FLOOR;
  assign req_mask  = req_ok ? floor_mask(req_floor) : '0;
  assign req_here  = req_ok && req_floor == cur_floor;
  assign cur_mask  = floor_mask(cur_floor);
  assign next_step = dir_up ? ((cur_floor == TOP_FLOOR)    ? cur_floor : cur_floor + 1'b1)
                            : ((cur_floor == FLOOR_BOTTOM) ? cur_floor : cur_floor - 1'b1);
  assign step_mask = floor_mask(next_step);
  assign req_step  = req_ok && req_floor == next_step;

  elevator_tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .en       (state != IDLE),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_n  = state;
    floor_n  = cur_floor;
    dir_n    = dir_up;
    open_n   = open_req;
    set_mask = '0;
    clr_mask = '0;
    tmr_load = 1'b0;
    tmr_val  = MOVE_LOAD;
    pick     = '0;
    case (state)
      IDLE: begin
        if (open_req || |(pending & cur_mask)) begin
          state_n  = DOOR;
          clr_mask = cur_mask;
          open_n   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
        end else if (|pending) begin
          pick     = pick_dir(pending, cur_floor, 1'b1);
          state_n  = MOVE;
          dir_n    = pick[0];
          tmr_load = 1'b1;
        end
        // a call for the parked floor opens the door without ever entering pending
        if (req_here && state_n == IDLE) open_n = 1'b1;
        else if (!(req_here && state_n == DOOR)) set_mask = req_mask;
      end
      MOVE: begin
        if (tmr_done) begin
          floor_n = next_step;
          if (|((pending | req_mask) & step_mask)) begin
            state_n  = DOOR;
            clr_mask = step_mask;
            tmr_load = 1'b1;
            tmr_val  = DOOR_LOAD;
          end else begin
            pick = pick_dir(pending, next_step, dir_up);
            if (pick[1]) begin
              dir_n    = pick[0];
              tmr_load = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
        end
        if (!(tmr_done && req_step)) set_mask = req_mask;
      end
      DOOR: begin
        if (req_here) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
        end else begin
          set_mask = req_mask;
          if (tmr_done) begin
            pick = pick_dir(pending, cur_floor, dir_up);
            if (pick[1]) begin
              state_n  = MOVE;
              dir_n    = pick[0];
              tmr_load = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    pend_n = (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_floor <= FLOOR_BOTTOM;
      dir_up    <= 1'b1;
      pending   <= '0;
      open_req  <= 1'b0;
    end else begin
      state     <= state_n;
      cur_floor <= floor_n;
      dir_up    <= dir_n;
      pending   <= pend_n;
      open_req  <= open_n;
    end
  end

  assign moving    = (state == MOVE);
  assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scenario bench: expected door openings queued per scenario, checked by a monitor.
module tb_elevator_scheduler;

  localparam int NF = 5;
  localparam int MT = 2;
  localparam int DT = 3;

  localparam int W_IDLE = 0;
  localparam int W_MOVE = 1;
  localparam int W_DOOR = 2;
  localparam int W_DCNT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          req_valid = 1'b0;
  logic [2:0]    req_floor = 3'd0;
  logic [2:0]    cur_floor;
  logic          dir_up, moving, door_open;
  logic [NF-1:0] pending;

  typedef struct {
    int floor;
    int ticks;
  } door_exp_t;

  door_exp_t sb[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        tick_div = 0;
  int        step_cnt = 0;
  int        door_cnt = 0;
  logic      t_move = 1'b0;
  logic      t_door = 1'b0;
  logic      prev_door = 1'b0;
  logic [2:0] prev_floor = 3'd1;

  elevator_scheduler #(.NUM_FLOORS(NF), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .cur_floor (cur_floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // tick pulses one cycle in three
  always @(posedge clk) begin
    #1;
    if (tick_div == 2) begin
      tick     = 1'b1;
      tick_div = 0;
    end else begin
      tick     = 1'b0;
      tick_div = tick_div + 1;
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: each floor change is a one-floor step taking MT ticks of MOVE;
  // each door opening must match the queue head in floor and ticks held.
  always @(negedge clk) begin
    if (!rst) begin
      prev_floor = 3'd1;
      prev_door  = 1'b0;
      step_cnt   = 0;
      door_cnt   = 0;
      t_move     = 1'b0;
      t_door     = 1'b0;
    end else begin
      int d;
      door_exp_t e;
      step_cnt = step_cnt + int'(t_move);
      door_cnt = door_cnt + int'(t_door);
      if (cur_floor != prev_floor) begin
        d = int'(cur_floor) - int'(prev_floor);
        check_val("step_size", (d < 0) ? -d : d, 1);
        check_val("step_ticks", step_cnt, MT);
        step_cnt = 0;
      end
      if (door_open && !prev_door) begin
        check_val("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) check_val("door_floor", int'(cur_floor), sb[0].floor);
        door_cnt = 0;
      end
      if (!door_open && prev_door && sb.size() > 0) begin
        e = sb.pop_front();
        check_val("door_ticks", door_cnt, e.ticks);
      end
      t_move     = moving && tick;
      t_door     = door_open && tick;
      prev_floor = cur_floor;
      prev_door  = door_open;
    end
  end

  function automatic logic cond_met(input int what, input int arg);
    case (what)
      W_IDLE:  cond_met = !moving && !door_open && pending == '0;
      W_MOVE:  cond_met = moving;
      W_DOOR:  cond_met = door_open && (arg == 0 || int'(cur_floor) == arg);
      default: cond_met = (door_cnt == arg);
    endcase
  endfunction

  task automatic wait_until(input string tag, input int what, input int arg);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #3;
      if (cond_met(what, arg)) return;
    end
    check_val(tag, int'(cond_met(what, arg)), 1);
  endtask

  // mode 0: any cycle, 1: cycle without tick, 2: cycle with tick
  task automatic send_req(input int f, input int mode);
    @(posedge clk);
    #2;
    while ((mode == 1 && tick) || (mode == 2 && !tick)) begin
      @(posedge clk);
      #2;
    end
    req_valid = 1'b1;
    req_floor = 3'(f);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    req_floor = 3'd0;
  endtask

  task automatic push_door(input int f, input int t);
    door_exp_t e;
    e.floor = f;
    e.ticks = t;
    sb.push_back(e);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_floor", int'(cur_floor), 1);
    check_val("rst_dir", int'(dir_up), 1);
    check_val("rst_moving", int'(moving), 0);
    check_val("rst_door", int'(door_open), 0);
    check_val("rst_pending", int'(pending), 0);
    @(posedge clk);
    #2 rst = 1'b1;

    // single request, floor 1 -> 4
    push_door(4, DT);
    send_req(4, 0);
    @(negedge clk);
    check_val("lat_pending", int'(pending), 8);
    check_val("lat_not_moving", int'(moving), 0);
    @(negedge clk);
    check_val("lat_moving", int'(moving), 1);
    check_val("lat_dir", int'(dir_up), 1);
    wait_until("idle_after_4", W_IDLE, 0);
    check_val("at_4", int'(cur_floor), 4);

    // SCAN: 4 -> 2, then 3 going up with {1,5} pending: 5 before 1
    push_door(2, DT);
    push_door(3, DT);
    push_door(5, DT);
    push_door(1, DT);
    send_req(2, 0);
    wait_until("idle_at_2", W_IDLE, 0);
    send_req(3, 0);
    wait_until("door_at_3", W_DOOR, 3);
    send_req(1, 0);
    send_req(5, 0);
    check_val("scan_pending", int'(pending), 5'b10001);
    wait_until("door_at_5", W_DOOR, 5);
    check_val("scan_dir_up", int'(dir_up), 1);
    wait_until("leave_5", W_MOVE, 0);
    check_val("scan_dir_down", int'(dir_up), 0);
    wait_until("idle_at_1", W_IDLE, 0);
    check_val("at_1", int'(cur_floor), 1);

    // request for parked floor, then re-hold after two door ticks
    push_door(1, 2 + DT);
    send_req(1, 0);
    @(negedge clk);
    check_val("here_pending0", int'(pending), 0);
    check_val("here_door0", int'(door_open), 0);
    @(negedge clk);
    check_val("here_door1", int'(door_open), 1);
    check_val("here_pending1", int'(pending), 0);
    wait_until("door_two_ticks", W_DCNT, 2);
    req_valid = 1'b1;
    req_floor = 3'd1;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    req_floor = 3'd0;
    @(negedge clk);
    check_val("rehold_pending", int'(pending), 0);
    check_val("rehold_door", int'(door_open), 1);
    wait_until("idle_after_rehold", W_IDLE, 0);

    // invalid floors ignored; request coinciding with tick still captured
    send_req(0, 0);
    send_req(6, 0);
    send_req(7, 0);
    @(negedge clk);
    check_val("inv_pending", int'(pending), 0);
    check_val("inv_moving", int'(moving), 0);
    check_val("inv_door", int'(door_open), 0);
    push_door(3, DT);
    send_req(3, 2);
    @(negedge clk);
    check_val("tick_req_pending", int'(pending), 5'b00100);
    wait_until("idle_at_3", W_IDLE, 0);
    check_val("at_3", int'(cur_floor), 3);

    // asynchronous reset in the middle of a move
    send_req(5, 0);
    wait_until("move_from_3", W_MOVE, 0);
    @(posedge clk);
    #3;
    check_val("pre_rst_floor", int'(cur_floor), 3);
    check_val("pre_rst_moving", int'(moving), 1);
    rst = 1'b0;
    #1;
    check_val("mid_rst_floor", int'(cur_floor), 1);
    check_val("mid_rst_pending", int'(pending), 0);
    check_val("mid_rst_moving", int'(moving), 0);
    check_val("mid_rst_door", int'(door_open), 0);
    check_val("mid_rst_dir", int'(dir_up), 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);
    check_val("post_rst_moving", int'(moving), 0);
    check_val("post_rst_floor", int'(cur_floor), 1);
    check_val("post_rst_pending", int'(pending), 0);

    check_val("sb_drained", int'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
